// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the system controller: command opcodes, operand
// register addresses and the receive-side FSM state encoding.
package sys_ctrl_pkg;

    localparam logic [7:0] CMD_RF_WR   = 8'hAA;
    localparam logic [7:0] CMD_RF_RD   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int unsigned OPA_ADDR = 0;
    localparam int unsigned OPB_ADDR = 1;

    typedef enum logic [3:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        OP_A,
        OP_B,
        ALU_FUN_S,
        ALU_WAIT
    } state_e;

endpackage

// File: rtl/sys_ctrl_rx_if.sv
// Byte-stream input and RF/ALU command bus of the receive-side controller.
// master = the controller issuing commands, slave = UART/RF/ALU side.
interface sys_ctrl_rx_if #(
    parameter int DATA_WIDTH = 8,
    parameter int RF_ADDR    = 4,
    parameter int FUN_WIDTH  = 4
);
    logic [DATA_WIDTH-1:0] UART_RX_DATA;
    logic                  UART_RX_VLD;
    logic                  RF_RdData_VLD;
    logic                  ALU_OUT_VLD;
    logic [RF_ADDR-1:0]    RF_Address;
    logic [DATA_WIDTH-1:0] RF_WrData;
    logic                  RF_WrEn;
    logic                  RF_RdEn;
    logic [FUN_WIDTH-1:0]  ALU_FUN;
    logic                  ALU_EN;
    logic                  CLK_GATE_EN;

    modport master (
        input  UART_RX_DATA, UART_RX_VLD, RF_RdData_VLD, ALU_OUT_VLD,
        output RF_Address, RF_WrData, RF_WrEn, RF_RdEn, ALU_FUN, ALU_EN, CLK_GATE_EN
    );

    modport slave (
        output UART_RX_DATA, UART_RX_VLD, RF_RdData_VLD, ALU_OUT_VLD,
        input  RF_Address, RF_WrData, RF_WrEn, RF_RdEn, ALU_FUN, ALU_EN, CLK_GATE_EN
    );
endinterface

// File: rtl/sys_ctrl_rx.sv
// Receive-side system controller: parses UART command frames into RF
// writes/reads and ALU operations, holding the ALU clock gate while busy.
module sys_ctrl_rx
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int RF_ADDR    = 4,
    parameter int FUN_WIDTH  = 4
) (
    input  logic          CLK,
    input  logic          RST,
    sys_ctrl_rx_if.master bus
);

    state_e                state, state_nxt;
    logic [RF_ADDR-1:0]    wr_addr_q, wr_addr_nxt;
    logic [RF_ADDR-1:0]    address_q, address_nxt;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_nxt;
    logic [FUN_WIDTH-1:0]  fun_q, fun_nxt;
    logic                  wr_en_q, wr_en_nxt;
    logic                  rd_en_q, rd_en_nxt;
    logic                  alu_en_q, alu_en_nxt;
    logic                  gate_q, gate_nxt;

    logic [DATA_WIDTH-1:0] rx_byte;
    logic                  rx_vld;

    assign rx_byte = bus.UART_RX_DATA;
    assign rx_vld  = bus.UART_RX_VLD;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_nxt   = state;
        wr_addr_nxt = wr_addr_q;
        address_nxt = address_q;
        wr_data_nxt = wr_data_q;
        fun_nxt     = fun_q;
        wr_en_nxt   = 1'b0;
        rd_en_nxt   = 1'b0;
        alu_en_nxt  = 1'b0;
        gate_nxt    = gate_q;

        case (state)
            IDLE: begin
                if (rx_vld) begin
                    if (rx_byte == DATA_WIDTH'(CMD_RF_WR))        state_nxt = WR_ADDR;
                    else if (rx_byte == DATA_WIDTH'(CMD_RF_RD))   state_nxt = RD_ADDR;
                    else if (rx_byte == DATA_WIDTH'(CMD_ALU_OP))  state_nxt = OP_A;
                    else if (rx_byte == DATA_WIDTH'(CMD_ALU_NOP)) state_nxt = ALU_FUN_S;
                end
            end
            WR_ADDR: if (rx_vld) begin
                wr_addr_nxt = rx_byte[RF_ADDR-1:0];
                state_nxt   = WR_DATA;
            end
            WR_DATA: if (rx_vld) begin
                address_nxt = wr_addr_q;
                wr_data_nxt = rx_byte;
                wr_en_nxt   = 1'b1;
                state_nxt   = IDLE;
            end
            RD_ADDR: if (rx_vld) begin
                address_nxt = rx_byte[RF_ADDR-1:0];
                rd_en_nxt   = 1'b1;
                state_nxt   = RD_WAIT;
            end
            // Bytes arriving while a transaction is outstanding are dropped.
            RD_WAIT: if (bus.RF_RdData_VLD) state_nxt = IDLE;
            OP_A: if (rx_vld) begin
                address_nxt = RF_ADDR'(OPA_ADDR);
                wr_data_nxt = rx_byte;
                wr_en_nxt   = 1'b1;
                state_nxt   = OP_B;
            end
            OP_B: if (rx_vld) begin
                address_nxt = RF_ADDR'(OPB_ADDR);
                wr_data_nxt = rx_byte;
                wr_en_nxt   = 1'b1;
                state_nxt   = ALU_FUN_S;
            end
            ALU_FUN_S: if (rx_vld) begin
                fun_nxt    = rx_byte[FUN_WIDTH-1:0];
                alu_en_nxt = 1'b1;
                gate_nxt   = 1'b1;
                state_nxt  = ALU_WAIT;
            end
            ALU_WAIT: if (bus.ALU_OUT_VLD) begin
                gate_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            wr_addr_q <= '0;
            address_q <= '0;
            wr_data_q <= '0;
            fun_q     <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            alu_en_q  <= 1'b0;
            gate_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state     <= state_nxt;
            wr_addr_q <= wr_addr_nxt;
            address_q <= address_nxt;
            wr_data_q <= wr_data_nxt;
            fun_q     <= fun_nxt;
            wr_en_q   <= wr_en_nxt;
            rd_en_q   <= rd_en_nxt;
            alu_en_q  <= alu_en_nxt;
            gate_q    <= gate_nxt;
        end
    end

    assign bus.RF_Address  = address_q;
    assign bus.RF_WrData   = wr_data_q;
    assign bus.RF_WrEn     = wr_en_q;
    assign bus.RF_RdEn     = rd_en_q;
    assign bus.ALU_FUN     = fun_q;
    assign bus.ALU_EN      = alu_en_q;
    assign bus.CLK_GATE_EN = gate_q;

endmodule

// File: tb/tb_sys_ctrl_rx.sv
// Bench for sys_ctrl_rx: directed frames followed by random byte/strobe
// traffic, compared every cycle against a frame-level reference model.
module tb_sys_ctrl_rx;

    logic CLK;
    logic RST;

    sys_ctrl_rx_if bus ();

    sys_ctrl_rx dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: tracks the current command and how many argument
    // bytes it has collected, plus whether a read or ALU op is outstanding.
    logic [7:0] m_cmd;      // 0 = no frame in progress
    int         m_n;
    logic [3:0] m_addr;
    bit         m_wait_rd, m_wait_alu;

    logic [3:0] e_addr;
    logic [7:0] e_wdata;
    logic [3:0] e_fun;
    bit         e_wren, e_rden, e_aluen, e_gate;

    task automatic model_reset();
        m_cmd = 8'h00; m_n = 0; m_addr = 4'h0;
        m_wait_rd = 0; m_wait_alu = 0;
        e_addr = 4'h0; e_wdata = 8'h00; e_fun = 4'h0;
        e_wren = 0; e_rden = 0; e_aluen = 0; e_gate = 0;
    endtask

    task automatic model_edge(input bit v, input logic [7:0] d, input bit rv, input bit av);
        e_wren = 0; e_rden = 0; e_aluen = 0;
        if (m_wait_rd) begin
            if (rv) m_wait_rd = 0;
        end else if (m_wait_alu) begin
            if (av) begin m_wait_alu = 0; e_gate = 0; end
        end else if (v) begin
            if (m_cmd == 8'h00) begin
                if (d == 8'hAA || d == 8'hBB || d == 8'hCC || d == 8'hDD) begin
                    m_cmd = d; m_n = 0;
                end
            end else begin
                m_n++;
                case (m_cmd)
                    8'hAA: if (m_n == 1) m_addr = d[3:0];
                           else begin e_wren = 1; e_addr = m_addr; e_wdata = d; m_cmd = 8'h00; end
                    8'hBB: begin e_rden = 1; e_addr = d[3:0]; m_wait_rd = 1; m_cmd = 8'h00; end
                    8'hCC: if (m_n == 1) begin e_wren = 1; e_addr = 4'd0; e_wdata = d; end
                           else if (m_n == 2) begin e_wren = 1; e_addr = 4'd1; e_wdata = d; end
                           else begin e_aluen = 1; e_fun = d[3:0]; e_gate = 1; m_wait_alu = 1; m_cmd = 8'h00; end
                    default: begin e_aluen = 1; e_fun = d[3:0]; e_gate = 1; m_wait_alu = 1; m_cmd = 8'h00; end
                endcase
            end
        end
    endtask

    task automatic compare_all(input string ph);
        check({ph, ".RF_WrEn"},     32'(bus.RF_WrEn),     32'(e_wren));
        check({ph, ".RF_RdEn"},     32'(bus.RF_RdEn),     32'(e_rden));
        check({ph, ".ALU_EN"},      32'(bus.ALU_EN),      32'(e_aluen));
        check({ph, ".CLK_GATE_EN"}, 32'(bus.CLK_GATE_EN), 32'(e_gate));
        check({ph, ".RF_Address"},  32'(bus.RF_Address),  32'(e_addr));
        check({ph, ".RF_WrData"},   32'(bus.RF_WrData),   32'(e_wdata));
        check({ph, ".ALU_FUN"},     32'(bus.ALU_FUN),     32'(e_fun));
    endtask

    // One clock cycle: drive inputs, let the edge happen, then compare #1 later.
    task automatic step(input string ph, input bit v, input logic [7:0] d, input bit rv, input bit av);
        bus.UART_RX_VLD   = v;
        bus.UART_RX_DATA  = d;
        bus.RF_RdData_VLD = rv;
        bus.ALU_OUT_VLD   = av;
        @(posedge CLK);
        model_edge(v, d, rv, av);
        #1;
        compare_all(ph);
    endtask

    task automatic send(input string ph, input logic [7:0] d);
        step(ph, 1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic idle(input string ph, input int n);
        for (int i = 0; i < n; i++) step(ph, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Reset pulse placed mid-cycle: outputs must clear without waiting for an edge.
    task automatic do_reset(input string ph);
        bus.UART_RX_VLD = 1'b0; bus.RF_RdData_VLD = 1'b0; bus.ALU_OUT_VLD = 1'b0;
        #2 RST = 1'b0;
        #1 model_reset();
        compare_all({ph, ".async"});
        @(posedge CLK);
        #1 compare_all({ph, ".held"});
        RST = 1'b1;
    endtask

    initial begin
        RST = 1'b0;
        bus.UART_RX_VLD = 1'b0; bus.UART_RX_DATA = 8'h00;
        bus.RF_RdData_VLD = 1'b0; bus.ALU_OUT_VLD = 1'b0;
        model_reset();
        #1 compare_all("reset");
        @(posedge CLK);
        #1 RST = 1'b1;

        // RF write
        send("wr", 8'hAA); send("wr", 8'h05); send("wr", 8'h3C); idle("wr", 1);

        // RF read, dropped byte while waiting, completion, then a normal write
        send("rd", 8'hBB); send("rd", 8'h07); send("rd", 8'h55); idle("rd", 2);
        step("rd", 1'b0, 8'h00, 1'b1, 1'b0);
        send("rd", 8'hAA); send("rd", 8'h01); send("rd", 8'h02);

        // ALU with operands, completion five cycles later
        send("alu", 8'hCC); send("alu", 8'h12); send("alu", 8'h34); send("alu", 8'h02);
        idle("alu", 4);
        step("alu", 1'b0, 8'h00, 1'b0, 1'b1); idle("alu", 1);

        // ALU without operands, then a junk opcode in IDLE
        send("nop", 8'hDD); send("nop", 8'h0F); idle("nop", 1);
        step("nop", 1'b0, 8'h00, 1'b0, 1'b1);
        send("nop", 8'h7E); idle("nop", 1);

        // Completion on the request edge is not seen; byte with completion is dropped
        send("edge", 8'hBB);
        step("edge", 1'b1, 8'hF9, 1'b1, 1'b0);
        step("edge", 1'b1, 8'hAA, 1'b1, 1'b0);
        send("edge", 8'h03); idle("edge", 1);

        // Reset mid-frame aborts it
        send("rst", 8'hAA); send("rst", 8'h03);
        do_reset("rst");
        send("rst", 8'hAA); send("rst", 8'h04); send("rst", 8'h99); idle("rst", 1);

        // Random traffic: opcode-heavy bytes, sporadic completions, rare resets
        for (int i = 0; i < 4000; i++) begin
            logic [7:0] b;
            int         r;
            r = int'($urandom_range(0, 9));
            case (r)
                0: b = 8'hAA;
                1: b = 8'hBB;
                2: b = 8'hCC;
                3: b = 8'hDD;
                default: b = 8'($urandom);
            endcase
            if ($urandom_range(0, 599) == 0) do_reset("rand");
            else step("rand", $urandom_range(0, 2) != 0, b,
                      $urandom_range(0, 6) == 0, $urandom_range(0, 6) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
